main_mem_ctrl: RTL
==================

Name: main_mem_ctrl

Overview:
Main-memory controller: the responder end of the icache and dcache memory-controller request/response interfaces driven by the core. It arbitrates between the two cache ports and services one block request at a time. Each request gets a fixed-latency response from an internal block-granular memory array. It sits in the top-level testbench/SoC next to the core, and it also exposes a backdoor init write port for program loading.

Parameters:
MAIN_MEM_BLOCK_ADDR_WIDTH, `MAIN_MEM_BLOCK_ADDR_WIDTH, block address width
BLOCK_DATA_WIDTH, `BLOCK_DATA_WIDTH, bits per block
N_BLOCKS, 1024, array depth; power of 2, <= 2**MAIN_MEM_BLOCK_ADDR_WIDTH
LATENCY, 4, cycles from request accept to response; >= 1

Ports:
clk  in  1  clock
rst_aL  in  1  asynchronous active-low reset
init_we  in  1  backdoor block write enable
init_block_addr  in  MAIN_MEM_BLOCK_ADDR_WIDTH  backdoor address
init_block_data  in  BLOCK_DATA_WIDTH  backdoor data
icache_req_valid  in  1  icache read request
icache_req_block_addr  in  MAIN_MEM_BLOCK_ADDR_WIDTH  icache block address
icache_req_ready  out  1  icache request accepted when valid&ready
icache_resp_valid  out  1  one-cycle response pulse
icache_resp_block_data  out  BLOCK_DATA_WIDTH  read data
dcache_req_valid  in  1  dcache request
dcache_req_type  in  1  0 read, 1 write (req_type_t)
dcache_req_block_addr  in  MAIN_MEM_BLOCK_ADDR_WIDTH  dcache block address
dcache_req_block_data  in  BLOCK_DATA_WIDTH  write data
dcache_req_ready  out  1  dcache request accepted when valid&ready
dcache_resp_valid  out  1  one-cycle response pulse (read data or write ack)
dcache_resp_block_data  out  BLOCK_DATA_WIDTH  read data; write data echoed for writes

Behaviour:
- Reset: the reset is asynchronous and active-low on rst_aL, clocked by clk.
  - Reset drives state=IDLE, cnt=0, last_grant=ICACHE, both resp_valid=0, both resp_data=0, pending request cleared.
  - Memory array contents are NOT reset.
- Reset mid-operation: any in-flight request is dropped, and no response is issued for it.
- FSM IDLE:
  - If init_we=1, both req_ready=0. The init write commits to mem[init_block_addr mod N_BLOCKS] at the clock edge.
  - Otherwise, a round-robin grant is made combinationally among valid requesters. If both are valid, grant goes to the port opposite last_grant.
  - Only the granted port sees req_ready=1. The other port's ready=0.
  - On handshake, the controller latches port id, type, address, write data and loads cnt=LATENCY-1, then moves to WAIT (or RESP when LATENCY=1). last_grant is updated.
  - No valid request: stay in IDLE.
- FSM WAIT: both req_ready=0. cnt decrements each cycle. When cnt==1, the next state is RESP.
- FSM RESP: lasts one cycle.
  - The granted port's resp_valid=1.
  - Read: resp_data = mem[addr mod N_BLOCKS].
  - Write: the array is updated at this clock edge and resp_data = written data.
  - The next state is IDLE, so the next accept happens at the earliest one cycle after RESP.
- Latency: request accepted at edge T; resp_valid high during cycle T+LATENCY.
- No response backpressure: the requester must accept the pulse.
- resp_data holds its last value after the pulse; resp_valid=0 except during RESP.
- init_we asserted outside IDLE: the write still commits at that edge. If it targets the same address as a pending RESP write, the dcache write wins.
- Address wrap: only the low log2(N_BLOCKS) address bits index the array; higher bits are ignored.
- Requests held valid while not ready must stay stable (requester's obligation). A requester may drop valid before handshake with no effect.
- icache requests are always reads.

Decomposition:
- Shared package/global defs: req_type_t (READ=0, WRITE=1), main_mem_block_addr_t, block_data_t, plus a mem_ctrl_state_t enum (IDLE, WAIT, RESP).
- One natural sub-module: main_mem_block_array, a single-port synchronous-write, asynchronous-read array with one write port muxed between init and dcache.
- Arbiter and FSM stay in main_mem_ctrl.

Test Plan:
1. Init-load mem[5]=0xA5A5..., then icache read addr 5, LATENCY=4, accept at edge T -> icache_resp_valid only in cycle T+4 with data 0xA5A5...; dcache_resp_valid stays 0.
2. dcache write addr 9 data 0x1234, then dcache read addr 9 -> write ack echoes 0x1234; read returns 0x1234.
3. Both valid in the same IDLE cycle after reset (last_grant=ICACHE) -> dcache is granted first and icache is served next. Repeat -> the order alternates, with no starvation.
4. icache read addr N_BLOCKS+3 -> returns mem[3].
5. rst_aL pulled low during WAIT -> no resp pulse, outputs 0, FSM in IDLE; prior memory contents intact on subsequent read.
6. init_we held high while icache_req_valid=1 in IDLE -> icache_req_ready=0 until init_we drops, then the request is accepted.

Source files
------------

// File: rtl/main_mem_ctrl_pkg.sv
// Shared types for the main-memory controller: request type, port id,
// FSM state encoding and the default widths used by the controller.
package main_mem_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 64;

  typedef logic [DEF_ADDR_WIDTH-1:0] main_mem_block_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] block_data_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } port_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_ctrl_state_t;

endpackage

// File: rtl/main_mem_block_array.sv
// Block-granular storage: synchronous writes from the init backdoor and the
// dcache write path, asynchronous read. Contents are never reset.
module main_mem_block_array #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 64,
  parameter int N_BLOCKS = 1024
) (
  input  logic              clk,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int IDX_W = $clog2(N_BLOCKS);

  logic [DATA_W-1:0] mem [N_BLOCKS];

  // The dcache write is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr[IDX_W-1:0]] <= init_data;
    if (dc_we)   mem[dc_addr[IDX_W-1:0]]   <= dc_data;
  end

  assign rd_data = mem[rd_addr[IDX_W-1:0]];

  // Address bits above the array index wrap and are deliberately ignored.
  if (IDX_W < ADDR_W) begin : g_wrap
    logic unused_hi;
    assign unused_hi = ^{init_addr[ADDR_W-1:IDX_W], dc_addr[ADDR_W-1:IDX_W],
                         rd_addr[ADDR_W-1:IDX_W]};
  end

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory controller: round-robin arbiter between icache and dcache
// request ports, one block request in flight, fixed-latency response.
module main_mem_ctrl
  import main_mem_ctrl_pkg::*;
#(
  parameter int MAIN_MEM_BLOCK_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BLOCK_DATA_WIDTH          = DEF_DATA_WIDTH,
  parameter int N_BLOCKS                  = 1024,
  parameter int LATENCY                   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_aL,
  input  logic                                 init_we,
  input  logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] init_block_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0]          init_block_data,
  input  logic                                 icache_req_valid,
  input  logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
  output logic                                 icache_req_ready,
  output logic                                 icache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0]          icache_resp_block_data,
  input  logic                                 dcache_req_valid,
  input  logic                                 dcache_req_type,
  input  logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0]          dcache_req_block_data,
  output logic                                 dcache_req_ready,
  output logic                                 dcache_resp_valid,
  output logic [BLOCK_DATA_WIDTH-1:0]          dcache_resp_block_data,
  output logic [1:0]                           state_dbg
);

  // Handshake: a request transfers on a rising edge where valid && ready.
  // Ready is only offered in IDLE, to the granted port, while init_we is low.
  // Responses are single-cycle pulses with no backpressure.

  localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_ctrl_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  port_t last_grant, grant, req_port;
  req_type_t req_type;
  logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] req_addr;
  logic [BLOCK_DATA_WIDTH-1:0] req_data, rd_data, resp_data;
  logic [BLOCK_DATA_WIDTH-1:0] ic_data_q, dc_data_q;
  logic accept, in_resp, dc_we;

  always_comb begin
    state_nx         = state;
    cnt_nx           = cnt;
    grant            = ICACHE;
    icache_req_ready = 1'b0;
    dcache_req_ready = 1'b0;
    accept           = 1'b0;
    case (state)
      IDLE: begin
        if (!init_we) begin
          if (icache_req_valid && dcache_req_valid)
            grant = (last_grant == ICACHE) ? DCACHE : ICACHE;
          else if (dcache_req_valid)
            grant = DCACHE;
          else
            grant = ICACHE;
          icache_req_ready = (grant == ICACHE) && icache_req_valid;
          dcache_req_ready = (grant == DCACHE) && dcache_req_valid;
          accept           = icache_req_ready || dcache_req_ready;
          if (accept) begin
            state_nx = (LATENCY == 1) ? RESP : WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= ICACHE;
      req_port   <= ICACHE;
      req_type   <= READ;
      req_addr   <= '0;
      req_data   <= '0;
      ic_data_q  <= '0;
      dc_data_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        last_grant <= grant;
        req_port   <= grant;
        req_type   <= (grant == DCACHE) ? req_type_t'(dcache_req_type) : READ;
        req_addr   <= (grant == DCACHE) ? dcache_req_block_addr : icache_req_block_addr;
        req_data   <= dcache_req_block_data;
      end
      // Capture the delivered data so each port's output holds after the pulse.
      if (in_resp) begin
        if (req_port == ICACHE) ic_data_q <= resp_data;
        else                    dc_data_q <= resp_data;
      end
    end
  end

  assign in_resp   = (state == RESP);
  assign dc_we     = in_resp && (req_type == WRITE);
  assign resp_data = (req_type == WRITE) ? req_data : rd_data;

  assign icache_resp_valid      = in_resp && (req_port == ICACHE);
  assign dcache_resp_valid      = in_resp && (req_port == DCACHE);
  assign icache_resp_block_data = icache_resp_valid ? resp_data : ic_data_q;
  assign dcache_resp_block_data = dcache_resp_valid ? resp_data : dc_data_q;
  assign state_dbg              = state;

  main_mem_block_array #(
    .ADDR_W  (MAIN_MEM_BLOCK_ADDR_WIDTH),
    .DATA_W  (BLOCK_DATA_WIDTH),
    .N_BLOCKS(N_BLOCKS)
  ) u_array (
    .clk      (clk),
    .init_we  (init_we),
    .init_addr(init_block_addr),
    .init_data(init_block_data),
    .dc_we    (dc_we),
    .dc_addr  (req_addr),
    .dc_data  (req_data),
    .rd_addr  (req_addr),
    .rd_data  (rd_data)
  );

endmodule
